// File: rtl/pc_ctrl.sv
// Program-counter controller: sequential fetch, redirects, stall, trap entry/return,
// misaligned-target detection and a double-fault halt state.
module pc_ctrl #(
  parameter int unsigned          XLEN        = 32,
  parameter logic [XLEN-1:0]      RESET_VEC   = '0,
  parameter logic [XLEN-1:0]      TRAP_VEC    = XLEN'(32'h100),
  parameter int unsigned          IALIGN_BITS = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            sel_next_pc_alu_out,
  input  logic [XLEN-1:0] alu_out,
  input  logic            trap_req,
  input  logic            mret,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4,
  output logic            pc_valid,
  output logic [XLEN-1:0] epc_out,
  output logic            misalign,
  output logic            in_handler,
  output logic            halted
);

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    HANDLER = 2'd2,
    HALT    = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << IALIGN_BITS) - 64'd1);

  state_t          state_r;
  state_t          state_next_s;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] pc_next_s;
  logic [XLEN-1:0] epc_r;
  logic [XLEN-1:0] epc_next_s;
  logic            misalign_r;
  logic            misalign_next_s;
  logic            pc_valid_r;
  logic            in_handler_r;
  logic            halted_r;
  logic [XLEN-1:0] pc_plus4_s;
  logic            bad_redirect_s;

  assign pc_plus4_s     = pc_r + XLEN'(4);
  assign bad_redirect_s = sel_next_pc_alu_out && ((alu_out & ALIGN_MASK) != '0);

  // State register and all registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= BOOT;
      pc_r         <= RESET_VEC;
      epc_r        <= '0;
      misalign_r   <= 1'b0;
      pc_valid_r   <= 1'b0;
      in_handler_r <= 1'b0;
      halted_r     <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      pc_r         <= pc_next_s;
      epc_r        <= epc_next_s;
      misalign_r   <= misalign_next_s;
      pc_valid_r   <= (state_next_s == RUN) || (state_next_s == HANDLER);
      in_handler_r <= (state_next_s == HANDLER);
      halted_r     <= (state_next_s == HALT);
    end
  end

  // Next-state selection
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      BOOT: state_next_s = RUN;
      RUN: begin
        if (trap_req || bad_redirect_s) begin
          state_next_s = HANDLER;
        end else begin
          state_next_s = RUN;
        end
      end
      HANDLER: begin
        if (trap_req || bad_redirect_s) begin
          state_next_s = HALT;
        end else if (mret) begin
          state_next_s = RUN;
        end else begin
          state_next_s = HANDLER;
        end
      end
      HALT:    state_next_s = HALT;
      default: state_next_s = BOOT;
    endcase
  end

  // Next PC / EPC / misalign; a double fault freezes the PC where it faulted
  always_comb begin
    pc_next_s       = pc_r;
    epc_next_s      = epc_r;
    misalign_next_s = 1'b0;
    case (state_r)
      BOOT: pc_next_s = RESET_VEC;
      RUN: begin
        if (trap_req) begin
          pc_next_s  = TRAP_VEC;
          epc_next_s = pc_r;
        end else if (bad_redirect_s) begin
          pc_next_s       = TRAP_VEC;
          epc_next_s      = pc_r;
          misalign_next_s = 1'b1;
        end else if (sel_next_pc_alu_out) begin
          pc_next_s = alu_out;
        end else if (stall) begin
          pc_next_s = pc_r;
        end else begin
          pc_next_s = pc_plus4_s;
        end
      end
      HANDLER: begin
        if (trap_req) begin
          pc_next_s = pc_r;
        end else if (bad_redirect_s) begin
          pc_next_s       = pc_r;
          misalign_next_s = 1'b1;
        end else if (mret) begin
          pc_next_s = epc_r;
        end else if (sel_next_pc_alu_out) begin
          pc_next_s = alu_out;
        end else if (stall) begin
          pc_next_s = pc_r;
        end else begin
          pc_next_s = pc_plus4_s;
        end
      end
      HALT:    pc_next_s = pc_r;
      default: pc_next_s = RESET_VEC;
    endcase
  end

  assign pc_out     = pc_r;
  assign pc_plus4   = pc_plus4_s;
  assign epc_out    = epc_r;
  assign misalign   = misalign_r;
  assign pc_valid   = pc_valid_r;
  assign in_handler = in_handler_r;
  assign halted     = halted_r;

endmodule
